ecall_stat_unit: RTL and testbench

- Sits directly downstream of the instruction-decode match gates in the single-cycle RISC-V CPU.
- Consumes the one-hot decode flags (ecall, jump, branch) and the register-file values a7/a0.
- Implements the ecall service: a7=10 halts the CPU, a7=34 latches a0 into the display register.
- Keeps the run statistics counters shown on the board display. It gates the PC write enable and provides a resume ("go") handshake.

---
 rtl/cpu_stat_pkg.sv | 11 +
 rtl/ecall_stat_unit_if.sv | 31 +++
 rtl/stat_counter.sv | 19 +
 rtl/ecall_stat_unit.sv | 89 ++++++++
 tb/tb_ecall_stat_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_stat_pkg.sv
// Shared constants for the ecall service / run-statistics block.
package cpu_stat_pkg;

  localparam int unsigned ECALL_HALT = 10;
  localparam int unsigned ECALL_DISP = 34;
  localparam int unsigned CNT_W_DEF  = 32;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

endpackage

// File: rtl/ecall_stat_unit_if.sv
// Decode-side bundle between the CPU datapath and ecall_stat_unit.
interface ecall_stat_unit_if
  import cpu_stat_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             is_ecall;
  logic             is_jump;
  logic             is_branch;
  logic             branch_taken;
  logic [31:0]      a7;
  logic [31:0]      a0;
  logic             go;
  logic             pc_en;
  logic             halted;
  logic [31:0]      disp_data;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] jump_cnt;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output is_ecall, is_jump, is_branch, branch_taken, a7, a0, go,
    input  pc_en, halted, disp_data, cycle_cnt, jump_cnt, branch_cnt, taken_cnt
  );

  modport slave (
    input  is_ecall, is_jump, is_branch, branch_taken, a7, a0, go,
    output pc_en, halted, disp_data, cycle_cnt, jump_cnt, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/stat_counter.sv
// Wrapping up-counter with enable, async active-low reset.
module stat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ecall_stat_unit.sv
// Ecall halt/display service, PC write gating and run-statistics counters.
module ecall_stat_unit
  import cpu_stat_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned HALT_CODE = ECALL_HALT,
  parameter int unsigned DISP_CODE = ECALL_DISP
) (
  input logic              clk,
  input logic              rst_n,
  ecall_stat_unit_if.slave bus
);

  logic [0:0]  state_q, state_d;
  logic        go_q;
  logic        skip_halt_q, skip_halt_d;
  logic [31:0] disp_q;
  logic        in_run;
  logic        halt_hit;
  logic        disp_hit;
  logic        go_rise;
  logic        pc_en;

  assign in_run   = (state_q == RUN);
  assign halt_hit = in_run & bus.is_ecall & (bus.a7 == 32'(HALT_CODE)) & ~skip_halt_q;
  assign disp_hit = in_run & bus.is_ecall & (bus.a7 == 32'(DISP_CODE));
  assign go_rise  = bus.go & ~go_q;
  assign pc_en    = in_run & ~halt_hit;

  always_comb begin
    state_d     = state_q;
    skip_halt_d = skip_halt_q;
    if (in_run) begin
      skip_halt_d = 1'b0;
      if (halt_hit) state_d = HALTED;
    end else if (go_rise) begin
      // Let the re-fetched halting ecall retire once instead of re-halting.
      state_d     = RUN;
      skip_halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      go_q        <= 1'b0;
      skip_halt_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= bus.go;
      skip_halt_q <= skip_halt_d;
      if (disp_hit) disp_q <= bus.a0;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.halted    = (state_q == HALTED);
  assign bus.disp_data = disp_q;

  stat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_en),
    .count (bus.cycle_cnt)
  );

  stat_counter #(.W(CNT_W)) u_jump_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_en & bus.is_jump),
    .count (bus.jump_cnt)
  );

  stat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_en & bus.is_branch),
    .count (bus.branch_cnt)
  );

  stat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_en & bus.is_branch & bus.branch_taken),
    .count (bus.taken_cnt)
  );

endmodule

// File: tb/tb_ecall_stat_unit.sv
// Self-checking bench: directed vector table, random run vs. reference model, wrap and async reset.
module tb_ecall_stat_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  ecall_stat_unit_if #(.CNT_W(32)) bus ();
  ecall_stat_unit_if #(.CNT_W(4))  bus4 ();

  ecall_stat_unit #(.CNT_W(32), .HALT_CODE(10), .DISP_CODE(34)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ecall_stat_unit #(.CNT_W(4), .HALT_CODE(10), .DISP_CODE(34)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  typedef struct {
    logic        ec, jp, br, tk;
    logic [31:0] a7, a0;
    logic        go;
    logic        pe, hl;
    logic [31:0] dp, cy, jm, bc, tc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ec, jp, br, tk, input logic [31:0] a7, a0, input logic go);
    bus.is_ecall = ec; bus.is_jump = jp; bus.is_branch = br; bus.branch_taken = tk;
    bus.a7 = a7; bus.a0 = a0; bus.go = go;
  endtask

  function automatic vec_t mk(input logic ec, jp, br, tk, input logic [31:0] a7, a0,
                              input logic go, pe, hl, input logic [31:0] dp, cy, jm, bc, tc);
    vec_t v;
    v.ec = ec; v.jp = jp; v.br = br; v.tk = tk; v.a7 = a7; v.a0 = a0; v.go = go;
    v.pe = pe; v.hl = hl; v.dp = dp; v.cy = cy; v.jm = jm; v.bc = bc; v.tc = tc;
    return v;
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_pc_en", 32'(bus.pc_en), 1);
    chk("rst_disp", bus.disp_data, 0);
    chk("rst_cycle", bus.cycle_cnt, 0);
  endtask

  // Reference model state
  bit          m_stop, m_pass, m_go_prev;
  logic [31:0] m_disp, m_cy, m_jm, m_bc, m_tc;

  initial begin
    bus4.is_ecall = 0; bus4.is_jump = 0; bus4.is_branch = 0; bus4.branch_taken = 0;
    bus4.a7 = 0; bus4.a0 = 0; bus4.go = 0;

    // ---------------- directed table ----------------
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0,0,0,0, 0,0, 0, 1,0, 0, i,0,0,0));
    for (int i = 1; i <= 3; i++) tbl.push_back(mk(0,1,0,0, 0,0, 0, 1,0, 0, 5+i,i,0,0));
    tbl.push_back(mk(0,0,1,1, 0,0, 0, 1,0, 0, 9,3,1,1));
    tbl.push_back(mk(0,0,1,0, 0,0, 0, 1,0, 0, 10,3,2,1));
    tbl.push_back(mk(0,0,1,1, 0,0, 0, 1,0, 0, 11,3,3,2));
    tbl.push_back(mk(0,0,1,0, 0,0, 0, 1,0, 0, 12,3,4,2));
    tbl.push_back(mk(0,0,0,1, 0,0, 0, 1,0, 0, 13,3,4,2));          // taken without branch
    tbl.push_back(mk(1,0,0,0, 34,32'hABCD, 0, 1,0, 32'hABCD, 14,3,4,2));
    tbl.push_back(mk(1,0,0,0, 5,32'h1111, 0, 1,0, 32'hABCD, 15,3,4,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 1, 1,0, 32'hABCD, 16,3,4,2));     // go in RUN ignored
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 1,0, 32'hABCD, 17,3,4,2));
    tbl.push_back(mk(1,0,0,0, 10,0, 0, 0,1, 32'hABCD, 17,3,4,2));    // halt
    tbl.push_back(mk(1,0,0,0, 10,0, 1, 0,0, 32'hABCD, 17,3,4,2));    // go rises -> resume
    tbl.push_back(mk(1,0,0,0, 10,0, 1, 1,0, 32'hABCD, 18,3,4,2));    // re-exec passes
    tbl.push_back(mk(0,0,0,0, 0,0, 1, 1,0, 32'hABCD, 19,3,4,2));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0,0, 10,0, 1, 0,1, 32'hABCD, 19,3,4,2));
    tbl.push_back(mk(1,0,0,0, 10,0, 0, 0,1, 32'hABCD, 19,3,4,2));
    tbl.push_back(mk(1,0,0,0, 10,0, 1, 0,0, 32'hABCD, 19,3,4,2));
    tbl.push_back(mk(1,0,0,0, 10,0, 0, 1,0, 32'hABCD, 20,3,4,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 1,0, 32'hABCD, 21,3,4,2));

    @(posedge clk); #1;
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].ec, tbl[i].jp, tbl[i].br, tbl[i].tk, tbl[i].a7, tbl[i].a0, tbl[i].go);
      #1;
      chk($sformatf("v%0d_pc_en", i), 32'(bus.pc_en), 32'(tbl[i].pe));
      @(posedge clk); #1;
      chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(tbl[i].hl));
      chk($sformatf("v%0d_disp", i), bus.disp_data, tbl[i].dp);
      chk($sformatf("v%0d_cycle", i), bus.cycle_cnt, tbl[i].cy);
      chk($sformatf("v%0d_jump", i), bus.jump_cnt, tbl[i].jm);
      chk($sformatf("v%0d_branch", i), bus.branch_cnt, tbl[i].bc);
      chk($sformatf("v%0d_taken", i), bus.taken_cnt, tbl[i].tc);
    end

    // ---------------- random run vs. model ----------------
    do_reset();
    m_stop = 0; m_pass = 0; m_go_prev = 0;
    m_disp = 0; m_cy = 0; m_jm = 0; m_bc = 0; m_tc = 0;
    for (int n = 0; n < 400; n++) begin
      logic ec, jp, br, tk, go, exec;
      logic [31:0] a7, a0;
      int unsigned r;
      r = $urandom_range(0, 9);
      ec = (r >= 6 && r <= 8); jp = (r == 3); br = (r == 4 || r == 5);
      if (r == 9) begin
        ec = 1'($urandom); jp = 1'($urandom); br = 1'($urandom);
      end
      tk = 1'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    a7 = 10;
        2:       a7 = 34;
        default: a7 = $urandom_range(0, 63);
      endcase
      a0 = $urandom;
      go = ($urandom_range(0, 2) == 0);
      drive(ec, jp, br, tk, a7, a0, go);

      exec = !m_stop && !(ec && a7 == 10 && !m_pass);
      #1;
      chk("rnd_pc_en", 32'(bus.pc_en), 32'(exec));
      if (exec) begin
        m_cy = m_cy + 1;
        if (jp) m_jm = m_jm + 1;
        if (br) m_bc = m_bc + 1;
        if (br && tk) m_tc = m_tc + 1;
      end
      if (!m_stop && ec && a7 == 34) m_disp = a0;
      if (!m_stop) begin
        m_pass = 0;
        if (!exec) m_stop = 1;
      end else if (go && !m_go_prev) begin
        m_stop = 0;
        m_pass = 1;
      end
      m_go_prev = go;

      @(posedge clk); #1;
      chk("rnd_halted", 32'(bus.halted), 32'(m_stop));
      chk("rnd_disp", bus.disp_data, m_disp);
      chk("rnd_cycle", bus.cycle_cnt, m_cy);
      chk("rnd_jump", bus.jump_cnt, m_jm);
      chk("rnd_branch", bus.branch_cnt, m_bc);
      chk("rnd_taken", bus.taken_cnt, m_tc);
    end

    // ---------------- 4-bit counter wrap ----------------
    rst4_n = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("wrap_cycle_16", 32'(bus4.cycle_cnt), 0);
    @(posedge clk); #1;
    chk("wrap_cycle_17", 32'(bus4.cycle_cnt), 1);
    chk("wrap_jump", 32'(bus4.jump_cnt), 0);

    // ---------------- async reset while halted ----------------
    do_reset();
    drive(1, 0, 0, 0, 34, 32'h1234, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 10, 0, 0);
    @(posedge clk); #1;
    chk("ar_pre_halted", 32'(bus.halted), 1);
    chk("ar_pre_disp", bus.disp_data, 32'h1234);
    rst_n = 1'b0;
    #2;
    chk("ar_halted", 32'(bus.halted), 0);
    chk("ar_disp", bus.disp_data, 0);
    chk("ar_cycle", bus.cycle_cnt, 0);
    chk("ar_jump", bus.jump_cnt, 0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
